// File: rtl/bi_bus_rx_decoder_pkg.sv
// bi_bus_rx_decoder_pkg: group layout helpers and stats counter widths for the bus-invert receive decoder
package bi_bus_rx_decoder_pkg;
    localparam int WORD_CNT_W = 16;
    localparam int INV_CNT_W  = 22;

    function automatic int num_wide(int k, int m);
        return (k + m) % m;
    endfunction

    function automatic int num_narrow(int k, int m);
        return m - num_wide(k, m);
    endfunction

    function automatic int grp_width(int g, int k, int m, int a);
        return (g < num_wide(k, m)) ? a - 1 : a - 2;
    endfunction

    function automatic int grp_start(int g, int k, int m, int a);
        int nw;
        nw = num_wide(k, m);
        return (g < nw) ? g * (a - 1) : nw * (a - 1) + (g - nw) * (a - 2);
    endfunction
endpackage

// File: rtl/bi_bus_rx_decoder_group_decode.sv
// bi_group_decode: restores one invert group, flipping its bits when the group's INV bit is set
module bi_group_decode #(
    parameter int W = 7
) (
    input  logic [W-1:0] x,
    input  logic         inv,
    output logic [W-1:0] s
);
    // one group's worth of XOR with its invert flag
    always_comb s = inv ? ~x : x;
endmodule

// File: rtl/bi_bus_rx_decoder.sv
// bi_bus_rx_decoder: bus-invert decode into a 2-entry valid/ready buffer; optional stats via BI_RX_STATS_EN
module bi_bus_rx_decoder
    import bi_bus_rx_decoder_pkg::*;
#(
    parameter int M = 5,
    parameter int k = 32,
    parameter int A = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  bus_valid,
    output logic                  bus_ready,
    input  logic [k+M-1:0]        bus_data,
    output logic                  s_valid,
    input  logic                  s_ready,
    output logic [k-1:0]          s_data,
    output logic [WORD_CNT_W-1:0] word_cnt,
    output logic [INV_CNT_W-1:0]  inv_cnt
);
    logic [k-1:0] x;
    logic [k-1:0] dec;
    logic [M-1:0] inv;
    logic [k-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   occ;
    logic         push;
    logic         pop;

    assign x   = bus_data[k+M-1:M];
    assign inv = bus_data[M-1:0];

    for (genvar g = 0; g < M; g++) begin : g_grp
        localparam int W = grp_width(g, k, M, A);
        localparam int O = grp_start(g, k, M, A);
        bi_group_decode #(.W(W)) u_dec (
            .x   (x[O +: W]),
            .inv (inv[g]),
            .s   (dec[O +: W])
        );
    end

    assign bus_ready = (occ != 2'd2) & ~flush;
    assign s_valid   = occ != 2'd0;
    assign s_data    = mem[rd_ptr];
    assign push      = bus_valid & bus_ready;
    assign pop       = s_valid & s_ready & ~flush;

    // buffer storage, pointers and occupancy; flush drops contents but keeps entry data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= (push & ~pop) ? occ + 2'd1 : (pop & ~push) ? occ - 2'd1 : occ;
        end
    end

`ifdef BI_RX_STATS_EN
    localparam int PW = $clog2(M + 1);
    logic [PW-1:0]      pc;
    logic [INV_CNT_W:0] inv_sum;

    // popcount of the INV field of the incoming word
    always_comb begin
        pc = '0;
        for (int i = 0; i < M; i++) pc = pc + PW'(inv[i]);
    end

    assign inv_sum = {1'b0, inv_cnt} + (INV_CNT_W + 1)'(pc);

    // saturating statistics, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            inv_cnt  <= '0;
        end else if (push) begin
            word_cnt <= &word_cnt ? word_cnt : word_cnt + 1'b1;
            inv_cnt  <= inv_sum[INV_CNT_W] ? '1 : inv_sum[INV_CNT_W-1:0];
        end
    end
`else
    assign word_cnt = '0;
    assign inv_cnt  = '0;
`endif
endmodule

// File: tb/tb_bi_bus_rx_decoder.sv
// tb_bi_bus_rx_decoder: scoreboard bench for bi_bus_rx_decoder; stats checks follow BI_RX_STATS_EN
module tb_bi_bus_rx_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        bus_valid = 1'b0;
    logic        bus_ready;
    logic [36:0] bus_data = '0;
    logic        s_valid;
    logic        s_ready = 1'b0;
    logic [31:0] s_data;
    logic [15:0] word_cnt;
    logic [21:0] inv_cnt;

    int          vectors = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic [31:0] cur_exp = '0;
    int          exp_words = 0;
    int          exp_inv = 0;

    bi_bus_rx_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_data  (bus_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .word_cnt  (word_cnt),
        .inv_cnt   (inv_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic int st(input int v);
`ifdef BI_RX_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // monitor: occupancy/ready tracking, in-order data compare, counter model
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_words = 0;
            exp_inv = 0;
        end else begin
            chk("s_valid", s_valid, q.size() != 0);
            chk("bus_ready", bus_ready, (q.size() < 2) && !flush);
            if (flush) q.delete();
            else begin
                if (s_valid && s_ready) begin
                    if (q.size() == 0) chk("unexpected_pop", 1, 0);
                    else chk("s_data", s_data, q.pop_front());
                end
                if (bus_valid && bus_ready) begin
                    q.push_back(cur_exp);
`ifdef BI_RX_STATS_EN
                    if (exp_words < 65535) exp_words++;
                    exp_inv += $countones(bus_data[4:0]);
`endif
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [4:0] inv, input logic [31:0] e);
        bit a;
        int n;
        n = 0;
        bus_valid = 1'b1;
        bus_data = {x, inv};
        cur_exp = e;
        do begin
            a = bus_ready;
            step();
            n++;
        end while (!a && n < 50);
        if (!a) chk("send_timeout", 0, 1);
        bus_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_bus_ready", bus_ready, 1);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_s_data", s_data, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_inv_cnt", inv_cnt, 0);

        s_ready = 1'b1;
        send(32'h0000_007F, 5'b00001, 32'h0000_0000);
        chk("lat_s_valid", s_valid, 1);
        chk("lat_s_data", s_data, 32'h0000_0000);
        chk("word_cnt_1", word_cnt, st(1));
        chk("inv_cnt_1", inv_cnt, st(1));
        send(32'hFFFF_FFFF, 5'b11111, 32'h0000_0000);
        send(32'h1234_5678, 5'b00000, 32'h1234_5678);
        chk("b2b_s_data", s_data, 32'h1234_5678);
        step();
        chk("word_cnt_3", word_cnt, st(3));
        chk("inv_cnt_6", inv_cnt, st(6));

        send(32'h0000_0080, 5'b00010, 32'h0000_3F00);
        send(32'h0000_0000, 5'b10000, 32'hFC00_0000);
        send(32'h0000_0000, 5'b00100, 32'h000F_C000);
        send(32'h0000_0000, 5'b01000, 32'h03F0_0000);
        send(32'hAAAA_AAAA, 5'b00101, 32'hAAA5_6AD5);
        repeat (2) step();
        chk("word_cnt_8", word_cnt, st(8));
        chk("inv_cnt_12", inv_cnt, st(12));

        s_ready = 1'b0;
        send(32'h1111_1111, 5'b00000, 32'h1111_1111);
        send(32'h2222_2222, 5'b00000, 32'h2222_2222);
        bus_valid = 1'b1;
        bus_data = {32'h3333_3333, 5'b00000};
        cur_exp = 32'h3333_3333;
        chk("bp_full_ready", bus_ready, 0);
        repeat (2) step();
        chk("bp_hold_ready", bus_ready, 0);
        s_ready = 1'b1;
        send(32'h3333_3333, 5'b00000, 32'h3333_3333);
        repeat (3) step();
        chk("bp_drained_ready", bus_ready, 1);
        chk("bp_drained_valid", s_valid, 0);

        s_ready = 1'b0;
        send(32'hA5A5_A5A5, 5'b00000, 32'hA5A5_A5A5);
        s_ready = 1'b1;
        send(32'h5A5A_5A5A, 5'b00000, 32'h5A5A_5A5A);
        chk("pp_s_valid", s_valid, 1);
        chk("pp_s_data", s_data, 32'h5A5A_5A5A);
        step();

        s_ready = 1'b0;
        send(32'h0F0F_0F0F, 5'b00000, 32'h0F0F_0F0F);
        send(32'hF0F0_F0F0, 5'b00000, 32'hF0F0_F0F0);
        flush = 1'b1;
        s_ready = 1'b1;
        chk("flush_bus_ready", bus_ready, 0);
        step();
        flush = 1'b0;
        chk("flush_s_valid", s_valid, 0);
        chk("flush_word_cnt", word_cnt, st(15));
        chk("flush_inv_cnt", inv_cnt, st(12));
        step();

        s_ready = 1'b0;
        send(32'hDEAD_BEEF, 5'b00011, 32'hDEAD_BEEF ^ 32'h0000_3FFF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_valid", s_valid, 0);
        chk("mid_rst_s_data", s_data, 0);
        chk("mid_rst_word_cnt", word_cnt, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_bus_ready", bus_ready, 1);

`ifdef BI_RX_STATS_EN
        s_ready = 1'b1;
        bus_valid = 1'b1;
        bus_data = '0;
        cur_exp = '0;
        repeat (65540) step();
        bus_valid = 1'b0;
        step();
        chk("sat_word_cnt", word_cnt, 16'hFFFF);
        chk("sat_model_word_cnt", word_cnt, exp_words);
        chk("sat_inv_cnt", inv_cnt, exp_inv);
`endif
        step();
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
